// File: rtl/sqrt_sched.sv
// sqrt_sched: round-robin scheduler sharing one sqrt pipeline among NREQ requesters, with ID tags, credits and drain.
// Define SQRT_SCHED_STATS_EN to build the stat_issued issue counter; otherwise it is tied to 0.
module sqrt_sched #(
   parameter int BITS     = 32,
   parameter int NREQ     = 4,
   parameter int SQRT_LAT = 32,
   parameter int MAX_OUT  = 8,
   parameter int IDW      = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*BITS-1:0] req_x,
   output logic [NREQ-1:0]      req_ready,
   output logic [BITS-1:0]      sqrt_x,
   input  logic [BITS-1:0]      sqrt_r,
   output logic                 res_valid,
   output logic [IDW-1:0]       res_id,
   output logic [BITS-1:0]      res_q,
   input  logic                 drain,
   output logic                 idle,
   output logic [31:0]          stat_issued
);
   localparam int CW = $clog2(MAX_OUT + 1);
   typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
   state_t state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d, grant, idx;
   logic issue;
   logic [NREQ-1:0] elig;
   logic [SQRT_LAT-1:0] v_q, v_d;
   logic [IDW-1:0] id_q [SQRT_LAT];
   logic [IDW-1:0] id_d [SQRT_LAT];
   logic [CW-1:0] out_q [NREQ];
   logic [CW-1:0] out_d [NREQ];

   assign res_valid = v_q[SQRT_LAT-1];
   assign res_id    = id_q[SQRT_LAT-1];
   assign res_q     = res_valid ? sqrt_r : '0;
   assign idle      = state_q == HALT;

   always_comb begin
      for (int i = 0; i < NREQ; i++)
         elig[i] = req_valid[i] && out_q[i] < CW'(MAX_OUT) && state_q == RUN && !drain && rst_n;
      grant = '0;
      issue = 1'b0;
      idx   = '0;
      // scanned from the far end so the nearest eligible requester after ptr wins
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = IDW'((int'(ptr_q) + k) % NREQ);
         if (elig[idx]) begin
            grant = idx;
            issue = 1'b1;
         end
      end
      req_ready = issue ? NREQ'(1) << grant : '0;
      sqrt_x    = issue ? req_x[int'(grant)*BITS +: BITS] : '0;
      ptr_d     = issue ? IDW'((int'(grant) + 1) % NREQ) : ptr_q;
      v_d       = (v_q << 1) | SQRT_LAT'(issue);
      id_d[0]   = grant;
      for (int s = 1; s < SQRT_LAT; s++)
         id_d[s] = id_q[s-1];
      for (int i = 0; i < NREQ; i++)
         out_d[i] = out_q[i] + CW'(issue && grant == IDW'(i)) - CW'(res_valid && res_id == IDW'(i));
      state_d = (state_q == RUN && drain) ? DRAIN :
                (state_q == DRAIN && v_q == '0) ? HALT :
                (state_q == HALT && !drain) ? RUN : state_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RUN;
         ptr_q   <= '0;
         v_q     <= '0;
         for (int s = 0; s < SQRT_LAT; s++)
            id_q[s] <= '0;
         for (int i = 0; i < NREQ; i++)
            out_q[i] <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         v_q     <= v_d;
         id_q    <= id_d;
         out_q   <= out_d;
      end
   end

`ifdef SQRT_SCHED_STATS_EN
   logic [31:0] stat_q, stat_d;
   always_comb stat_d = stat_q + 32'(issue);
   always_ff @(posedge clk) begin
      if (!rst_n)
         stat_q <= '0;
      else
         stat_q <= stat_d;
   end
   assign stat_issued = stat_q;
`else
   assign stat_issued = '0;
`endif

endmodule
